// File: rtl/mem_block_buffer.sv
// mem_block_buffer: staging FIFO between a word-oriented controller and a
// block-capable memory port. Writes are gathered from the controller, then
// handed to memory after an address handshake. Reads are collected from
// memory, then handed back to the controller. Each transfer ends with a
// one-cycle CLEAR that empties the FIFO and pulses mem_clear_o / done_o.
// Optional sticky protocol-exception flags are built when the macro
// MEM_BLOCK_BUFFER_EXCEPTION_EN is defined. Otherwise exception_o is tied to 0.
module mem_block_buffer #(
    parameter int BLOCK_WORDS = 4,
    parameter int ADDR_W      = 24
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              req_i,
    input  logic              reqBlock_i,
    input  logic              rw_i,
    input  logic [ADDR_W-1:0] add_i,
    input  logic              write_en_i,
    input  logic [31:0]       data_i,
    input  logic              read_ack_i,
    output logic              ready_write_o,
    output logic              ready_read_o,
    output logic [31:0]       data_o,
    output logic              done_o,
    output logic [3:0]        exception_o,
    output logic              mem_req_o,
    output logic              mem_reqBlock_o,
    output logic              mem_rw_o,
    output logic              mem_clear_o,
    output logic [ADDR_W-1:0] mem_add_o,
    output logic [31:0]       mem_data_o,
    input  logic              mem_ready_i,
    input  logic              mem_valid_i,
    input  logic              mem_done_i,
    input  logic [31:0]       mem_data_i
);

    localparam int PTR_W = $clog2(BLOCK_WORDS);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BLOCK_WORDS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WFILL,
        S_WISSUE,
        S_WSEND,
        S_WDONE,
        S_RISSUE,
        S_RRECV,
        S_RDRAIN,
        S_CLEAR
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Latched request and the req_i edge detector.
    logic              r_req_prev;
    logic              r_rw;
    logic              r_block;
    logic [ADDR_W-1:0] r_addr;

    // FIFO storage and bookkeeping.
    logic [31:0]       r_mem [BLOCK_WORDS];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_req_rise;
    logic              w_accept;
    logic              w_push_req;
    logic              w_pop_req;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_len;
    logic [31:0]       w_push_data;
    logic [31:0]       w_head;

    assign w_len       = r_block ? FULL_CNT : CNT_W'(1);
    assign w_req_rise  = req_i & ~r_req_prev;
    assign w_accept    = (r_state == S_IDLE) & w_req_rise;

    // Only the phase that owns a handshake may move data.
    // Stray strobes in any other phase are ignored.
    assign w_push_req  = ((r_state == S_WFILL) & write_en_i & (r_count < w_len)) |
                         ((r_state == S_RRECV) & mem_valid_i);
    assign w_pop_req   = ((r_state == S_WSEND) & mem_ready_i) |
                         ((r_state == S_RDRAIN) & read_ack_i);

    // Overflow and underflow attempts are dropped.
    assign w_push      = w_push_req & (r_count != FULL_CNT);
    assign w_pop       = w_pop_req & (r_count != '0);
    assign w_push_data = (r_state == S_RRECV) ? mem_data_i : data_i;
    assign w_head      = r_mem[r_rptr];

    // State register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = rw_i ? S_WFILL : S_RISSUE;
                end
            end
            // One extra cycle is spent with the FIFO at N, so ready_write_o
            // drops before the memory handshake starts.
            S_WFILL:  if (r_count == w_len) w_state_next = S_WISSUE;
            S_WISSUE: if (mem_ready_i) w_state_next = S_WSEND;
            S_WSEND:  if (w_pop && (r_count == CNT_W'(1))) w_state_next = S_WDONE;
            S_WDONE:  if (mem_done_i) w_state_next = S_CLEAR;
            S_RISSUE: if (mem_ready_i) w_state_next = S_RRECV;
            S_RRECV:  if (w_push && (r_count == (w_len - CNT_W'(1)))) w_state_next = S_RDRAIN;
            S_RDRAIN: if (w_pop && (r_count == CNT_W'(1))) w_state_next = S_CLEAR;
            S_CLEAR:  w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Output decode. The memory request fields are shown only while the
    // request is outstanding, and all outputs read 0 otherwise.
    always_comb begin
        ready_write_o  = 1'b0;
        ready_read_o   = 1'b0;
        data_o         = 32'h0;
        done_o         = 1'b0;
        mem_req_o      = 1'b0;
        mem_reqBlock_o = 1'b0;
        mem_rw_o       = 1'b0;
        mem_clear_o    = 1'b0;
        mem_add_o      = '0;
        mem_data_o     = 32'h0;
        case (r_state)
            S_WFILL: ready_write_o = (r_count < w_len);
            S_WISSUE, S_RISSUE: begin
                mem_req_o      = 1'b1;
                mem_rw_o       = r_rw;
                mem_reqBlock_o = r_block;
                mem_add_o      = r_addr;
            end
            S_WSEND: mem_data_o = w_head;
            S_RDRAIN: begin
                ready_read_o = (r_count != '0);
                data_o       = (r_count != '0) ? w_head : 32'h0;
            end
            S_CLEAR: begin
                mem_clear_o = 1'b1;
                done_o      = 1'b1;
            end
            default: ;
        endcase
    end

    // Request latch and req_i history. The history resets high, so a req_i
    // that is held across reset must fall and rise again before it counts.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_req_prev <= 1'b1;
            r_rw       <= 1'b0;
            r_block    <= 1'b0;
            r_addr     <= '0;
        end else begin
            r_req_prev <= req_i;
            if (w_accept) begin
                r_rw    <= rw_i;
                r_block <= reqBlock_i;
                r_addr  <= add_i;
            end
        end
    end

    // FIFO pointers and occupancy. CLEAR empties the FIFO. Pointers wrap at
    // the power-of-two depth.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (r_state == S_CLEAR) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // FIFO storage write port. It has no reset because stale words are
    // never visible past the count.
    always_ff @(posedge clock_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

`ifdef MEM_BLOCK_BUFFER_EXCEPTION_EN
    logic [3:0] r_exc;
    logic [3:0] w_exc_set;

    // Protocol violation detection.
    always_comb begin
        w_exc_set    = 4'b0;
        w_exc_set[0] = (r_state == S_WFILL) & write_en_i & (r_count == FULL_CNT);
        w_exc_set[1] = (r_state == S_RDRAIN) & read_ack_i & (r_count == '0);
        w_exc_set[2] = (r_state != S_RRECV) & mem_valid_i;
        w_exc_set[3] = (r_state != S_IDLE) & w_req_rise;
    end

    // Sticky exception flags. Only reset clears them.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_exc <= 4'b0;
        end else begin
            r_exc <= r_exc | w_exc_set;
        end
    end

    assign exception_o = r_exc;
`else
    assign exception_o = 4'b0;
`endif

endmodule

// File: tb/tb_mem_block_buffer.sv
// Testbench for mem_block_buffer. The stimulus process knows which phase
// of each transfer it is driving. It publishes the outputs that phase
// requires, and a negedge compare process checks every output every cycle.
// Directed transfers pin known values; randomized transfers follow them.
module tb_mem_block_buffer;
    localparam int BW = 4;
    localparam int AW = 24;
`ifdef MEM_BLOCK_BUFFER_EXCEPTION_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_i, reqBlock_i, rw_i, write_en_i, read_ack_i;
    logic [AW-1:0] add_i;
    logic [31:0]   data_i;
    logic          ready_write_o, ready_read_o, done_o;
    logic [31:0]   data_o;
    logic [3:0]    exception_o;
    logic          mem_req_o, mem_reqBlock_o, mem_rw_o, mem_clear_o;
    logic [AW-1:0] mem_add_o;
    logic [31:0]   mem_data_o;
    logic          mem_ready_i, mem_valid_i, mem_done_i;
    logic [31:0]   mem_data_i;

    always #5 clk = ~clk;

    mem_block_buffer #(.BLOCK_WORDS(BW), .ADDR_W(AW)) dut (
        .clock_i(clk), .reset_i(rst),
        .req_i(req_i), .reqBlock_i(reqBlock_i), .rw_i(rw_i), .add_i(add_i),
        .write_en_i(write_en_i), .data_i(data_i), .read_ack_i(read_ack_i),
        .ready_write_o(ready_write_o), .ready_read_o(ready_read_o),
        .data_o(data_o), .done_o(done_o), .exception_o(exception_o),
        .mem_req_o(mem_req_o), .mem_reqBlock_o(mem_reqBlock_o),
        .mem_rw_o(mem_rw_o), .mem_clear_o(mem_clear_o),
        .mem_add_o(mem_add_o), .mem_data_o(mem_data_o),
        .mem_ready_i(mem_ready_i), .mem_valid_i(mem_valid_i),
        .mem_done_i(mem_done_i), .mem_data_i(mem_data_i)
    );

    // Expected outputs for the current cycle.
    logic          e_ready_write, e_ready_read, e_done, e_mem_req;
    logic          e_mem_block, e_mem_rw, e_mem_clear;
    logic [31:0]   e_data, e_mem_data;
    logic [AW-1:0] e_mem_add;
    logic [3:0]    exc_model, exc_pend;
    bit            in_send;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    logic [31:0] wq[$];
    logic [31:0] rd_src[$];
    logic [31:0] rq[$];
    logic [31:0] send_log[$];
    logic [31:0] drain_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the expectation once per cycle.
    always @(negedge clk) begin
        chk("ready_write_o", 32'(ready_write_o), 32'(e_ready_write));
        chk("ready_read_o", 32'(ready_read_o), 32'(e_ready_read));
        chk("data_o", data_o, e_data);
        chk("done_o", 32'(done_o), 32'(e_done));
        chk("mem_req_o", 32'(mem_req_o), 32'(e_mem_req));
        chk("mem_reqBlock_o", 32'(mem_reqBlock_o), 32'(e_mem_block));
        chk("mem_rw_o", 32'(mem_rw_o), 32'(e_mem_rw));
        chk("mem_clear_o", 32'(mem_clear_o), 32'(e_mem_clear));
        chk("mem_add_o", 32'(mem_add_o), 32'(e_mem_add));
        chk("mem_data_o", mem_data_o, e_mem_data);
        chk("exception_o", 32'(exception_o), EXC_EN ? 32'(exc_model) : 32'h0);
        if (in_send && mem_ready_i) send_log.push_back(mem_data_o);
        if (e_ready_read && read_ack_i) drain_log.push_back(data_o);
        if (done_o) n_done++;
    end

    task automatic exp_idle();
        e_ready_write = 1'b0; e_ready_read = 1'b0; e_done = 1'b0;
        e_mem_req = 1'b0; e_mem_block = 1'b0; e_mem_rw = 1'b0;
        e_mem_clear = 1'b0; e_data = 32'h0; e_mem_data = 32'h0;
        e_mem_add = '0; in_send = 1'b0;
    endtask

    task automatic quiet();
        write_en_i = 1'b0; read_ack_i = 1'b0; mem_ready_i = 1'b0;
        mem_valid_i = 1'b0; mem_done_i = 1'b0;
    endtask

    // Advance one clock. Violations driven in the last cycle become visible
    // in the sticky flags from this edge onward.
    task automatic tick();
        @(posedge clk);
        exc_model = exc_model | exc_pend;
        exc_pend  = 4'b0;
        #1;
    endtask

    // Hold the address handshake for a random number of cycles.
    task automatic wait_ready();
        int  k;
        bit  r;
        k = 0;
        do begin
            r = (k >= 6) || ($urandom_range(0, 2) == 0);
            mem_ready_i = r;
            tick();
            k++;
        end while (!r);
        mem_ready_i = 1'b0;
    endtask

    // Write transfer of the words in wq. If abort_after >= 0, reset is
    // asserted in the send phase once that many words have been taken.
    task automatic do_write(input bit blk, input logic [AW-1:0] addr, input bit extra_we,
                            input bit hold_req, input bit inj_req, input int abort_after);
        int n, idx, tries;
        n = blk ? BW : 1;
        req_i = 1'b1; rw_i = 1'b1; reqBlock_i = blk; add_i = addr;
        tick();
        rw_i = 1'($urandom); reqBlock_i = 1'($urandom); add_i = AW'($urandom);
        if (!hold_req) req_i = 1'b0;
        exp_idle();
        e_ready_write = 1'b1;
        idx = 0;
        while (idx < n) begin
            read_ack_i = 1'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                write_en_i = 1'b1; data_i = wq[idx]; idx++;
            end else begin
                write_en_i = 1'b0; data_i = $urandom;
            end
            tick();
        end
        write_en_i = 1'b0; read_ack_i = 1'b0;
        e_ready_write = 1'b0;
        if (extra_we) begin
            write_en_i = 1'b1; data_i = 32'hBADBAD00;
            if (blk) exc_pend[0] = 1'b1;
        end
        tick();
        write_en_i = 1'b0;
        e_mem_req = 1'b1; e_mem_rw = 1'b1; e_mem_block = blk; e_mem_add = addr;
        wait_ready();
        exp_idle();
        in_send = 1'b1;
        idx = 0;
        while (idx < n) begin
            e_mem_data = wq[idx];
            if (idx == abort_after) begin
                rst = 1'b1;
                quiet();
                exp_idle();
                exc_model = 4'b0; exc_pend = 4'b0;
                #1;
                chk("reset_flags_now", 32'({ready_write_o, ready_read_o, done_o, mem_req_o,
                    mem_reqBlock_o, mem_rw_o, mem_clear_o, exception_o}), 32'h0);
                chk("reset_data_now", data_o | mem_data_o, 32'h0);
                chk("reset_addr_now", 32'(mem_add_o), 32'h0);
                tick();
                tick();
                rst = 1'b0;
                $display("txn write aborted by reset addr=%06h after %0d words", addr, idx);
                return;
            end
            mem_ready_i = ($urandom_range(0, 2) != 0);
            tick();
            if (mem_ready_i) idx++;
        end
        mem_ready_i = 1'b0;
        exp_idle();
        tries = inj_req ? $urandom_range(1, 4) : $urandom_range(0, 4);
        for (int k = 0; k < tries; k++) begin
            if (inj_req && k == 0) begin
                req_i = 1'b1; exc_pend[3] = 1'b1;
            end else if (!hold_req) begin
                req_i = 1'b0;
            end
            tick();
        end
        if (!hold_req) req_i = 1'b0;
        mem_done_i = 1'b1;
        tick();
        mem_done_i = 1'b0;
        e_mem_clear = 1'b1; e_done = 1'b1;
        tick();
        exp_idle();
        if (hold_req) begin
            repeat (3) tick();
            req_i = 1'b0;
        end
        $display("txn write blk=%0d addr=%06h words=%0d", blk, addr, n);
    endtask

    // Read transfer. Words come from rd_src while it has entries, otherwise
    // they are random.
    task automatic do_read(input bit blk, input logic [AW-1:0] addr, input bit inj_valid);
        int n, got;
        n = blk ? BW : 1;
        req_i = 1'b1; rw_i = 1'b0; reqBlock_i = blk; add_i = addr;
        tick();
        req_i = 1'b0; rw_i = 1'($urandom); reqBlock_i = 1'($urandom); add_i = AW'($urandom);
        exp_idle();
        e_mem_req = 1'b1; e_mem_rw = 1'b0; e_mem_block = blk; e_mem_add = addr;
        wait_ready();
        exp_idle();
        rq.delete();
        got = 0;
        while (got < n) begin
            mem_done_i = 1'($urandom); write_en_i = 1'($urandom); data_i = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                mem_valid_i = 1'b1;
                if (rd_src.size() > 0) mem_data_i = rd_src.pop_front();
                else mem_data_i = $urandom;
                rq.push_back(mem_data_i);
                got++;
            end else begin
                mem_valid_i = 1'b0; mem_data_i = $urandom;
            end
            tick();
        end
        quiet();
        while (rq.size() > 0) begin
            e_ready_read = 1'b1; e_data = rq[0];
            read_ack_i = ($urandom_range(0, 1) == 1);
            if (inj_valid && $urandom_range(0, 3) == 0) begin
                mem_valid_i = 1'b1; exc_pend[2] = 1'b1;
            end else begin
                mem_valid_i = 1'b0;
            end
            tick();
            if (read_ack_i) void'(rq.pop_front());
        end
        quiet();
        exp_idle();
        e_mem_clear = 1'b1; e_done = 1'b1;
        tick();
        exp_idle();
        $display("txn read blk=%0d addr=%06h words=%0d", blk, addr, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int nd;
        rst = 1'b1;
        req_i = 1'b0; reqBlock_i = 1'b0; rw_i = 1'b0; add_i = '0;
        data_i = 32'h0; mem_data_i = 32'h0;
        quiet();
        exp_idle();
        exc_model = 4'b0; exc_pend = 4'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state_flags", 32'({ready_write_o, ready_read_o, done_o, mem_req_o,
            mem_clear_o, exception_o}), 32'h0);
        rst = 1'b0;
        tick();

        // Single write of DEADBEEF to 0x10.
        wq = '{32'hDEADBEEF};
        send_log.delete();
        do_write(1'b0, 24'h000010, 1'b0, 1'b0, 1'b0, -1);
        chk("single_write_count", 32'(send_log.size()), 32'd1);
        chk("single_write_data", send_log[0], 32'hDEADBEEF);
        req_i = 1'b0; tick();

        // Block write 1..4 with a 5th write into a full FIFO and req held high.
        wq = '{32'h1, 32'h2, 32'h3, 32'h4};
        send_log.delete();
        nd = n_done;
        do_write(1'b1, 24'h000200, 1'b1, 1'b1, 1'b0, -1);
        chk("block_write_count", 32'(send_log.size()), 32'd4);
        chk("block_write_w0", send_log[0], 32'h1);
        chk("block_write_w1", send_log[1], 32'h2);
        chk("block_write_w2", send_log[2], 32'h3);
        chk("block_write_w3", send_log[3], 32'h4);
        chk("held_req_single_done", 32'(n_done - nd), 32'd1);
        chk("exception_after_overfill", 32'(exception_o), EXC_EN ? 32'h1 : 32'h0);
        req_i = 1'b0; tick();

        // Block read of A0..A3.
        rd_src = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        drain_log.delete();
        do_read(1'b1, 24'h000300, 1'b0);
        chk("block_read_count", 32'(drain_log.size()), 32'd4);
        chk("block_read_w0", drain_log[0], 32'hA0);
        chk("block_read_w1", drain_log[1], 32'hA1);
        chk("block_read_w2", drain_log[2], 32'hA2);
        chk("block_read_w3", drain_log[3], 32'hA3);
        req_i = 1'b0; tick();

        // Reset in the send phase after 2 words, then a fresh block write.
        wq = '{32'h11, 32'h22, 32'h33, 32'h44};
        do_write(1'b1, 24'h000400, 1'b0, 1'b0, 1'b0, 2);
        quiet();
        req_i = 1'b0; tick();
        wq = '{32'h55, 32'h66, 32'h77, 32'h88};
        send_log.delete();
        do_write(1'b1, 24'h000404, 1'b0, 1'b0, 1'b0, -1);
        chk("post_reset_count", 32'(send_log.size()), 32'd4);
        chk("post_reset_w0", send_log[0], 32'h55);
        chk("post_reset_w3", send_log[3], 32'h88);
        req_i = 1'b0; tick();

        // Randomized transfers.
        for (int t = 0; t < 40; t++) begin
            bit blk;
            logic [AW-1:0] addr;
            req_i = 1'b0;
            quiet();
            repeat ($urandom_range(1, 3)) tick();
            blk  = 1'($urandom);
            addr = AW'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                wq.delete();
                for (int i = 0; i < BW; i++) wq.push_back($urandom);
                do_write(blk, addr, 1'($urandom), 1'b0, ($urandom_range(0, 4) == 0), -1);
            end else begin
                rd_src.delete();
                do_read(blk, addr, ($urandom_range(0, 4) == 0));
            end
        end
        req_i = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
